dfp_sig_divide: RTL and testbench



---
 rtl/dfp_sig_divide.sv | 125 ++++++++++++
 tb/tb_dfp_sig_divide.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dfp_sig_divide.sv
// dfp_sig_divide: restoring BCD significand divider, one subtract-or-append step per clock.
// Produces a 2N-digit quotient of (a*10^N)/b, the final remainder and a leading-zero-digit count.
module dfp_sig_divide #(
    parameter int N = 36
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 ld,
    input  logic [N*4-1:0]       a,
    input  logic [N*4-1:0]       b,
    output logic [2*N*4-1:0]     q,
    output logic [(N+1)*4-1:0]   r,
    output logic [7:0]           lzcnt,
    output logic                 dbz,
    output logic                 done
);
    localparam int KW = $clog2(2*N+1);
    localparam logic [7:0] LZ_MAX = (2*N > 99) ? 8'h99 : 8'(((2*N)/10)*16 + (2*N)%10);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    logic [N*4-1:0]     dv;
    logic [N*4-1:0]     a_sh;
    logic [(N+1)*4-1:0] rem;
    logic [(N+1)*4-1:0] rem_sub;
    logic [(N+1)*4-1:0] rem_shl;
    logic [(N+1)*4-1:0] dvx;
    logic [3:0]         d;
    logic [KW-1:0]      k;
    logic               nz;
    logic               ge;
    logic               last;
    logic               bz;
    logic               append;
    logic [7:0]         lz_inc;
    logic [4:0]         dd;
    logic               bw;

    // BCD encodings order the same as their values, so a binary compare suffices
    assign dvx     = {4'h0, dv};
    assign bz      = b == '0;
    assign ge      = rem >= dvx;
    assign append  = state == RUN && !ge;
    assign last    = k == KW'(2*N-1);
    assign rem_shl = {rem[N*4-1:0], a_sh[N*4-1 -: 4]};
    assign done    = state != RUN;
    assign lz_inc  = lzcnt == 8'h99 ? lzcnt :
                     lzcnt[3:0] == 4'h9 ? {lzcnt[7:4] + 4'h1, 4'h0} :
                     {lzcnt[7:4], lzcnt[3:0] + 4'h1};

    always_comb begin
        rem_sub = '0;
        bw = 1'b0;
        dd = '0;
        for (int i = 0; i < N+1; i++) begin
            dd = {1'b0, rem[i*4 +: 4]} - {1'b0, dvx[i*4 +: 4]} - {4'h0, bw};
            rem_sub[i*4 +: 4] = dd[4] ? dd[3:0] + 4'ha : dd[3:0];
            bw = dd[4];
        end
    end

    always_comb begin
        state_n = state;
        if (ld)
            state_n = bz ? DONE : RUN;
        else if (append && last)
            state_n = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (ce)
            state <= state_n;
    end

    // a_sh feeds the dividend stream MS digit first; zeros shift in behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q     <= '0;
            r     <= '0;
            lzcnt <= '0;
            dbz   <= 1'b0;
            dv    <= '0;
            a_sh  <= '0;
            rem   <= '0;
            d     <= '0;
            k     <= '0;
            nz    <= 1'b0;
        end else if (ce) begin
            if (ld) begin
                dv    <= b;
                q     <= '0;
                d     <= '0;
                k     <= '0;
                nz    <= 1'b0;
                dbz   <= bz;
                lzcnt <= bz ? LZ_MAX : 8'h00;
                a_sh  <= {a[N*4-5:0], 4'h0};
                rem   <= {{(N*4){1'b0}}, a[N*4-1 -: 4]};
                if (bz)
                    r <= '0;
            end else if (state == RUN) begin
                if (ge) begin
                    rem <= rem_sub;
                    d   <= d + 4'h1;
                end else begin
                    q <= {q[2*N*4-5:0], d};
                    if (d == 4'h0 && !nz)
                        lzcnt <= lz_inc;
                    else
                        nz <= 1'b1;
                    d    <= '0;
                    rem  <= rem_shl;
                    a_sh <= {a_sh[N*4-5:0], 4'h0};
                    k    <= k + 1'b1;
                    if (last)
                        r <= rem;
                end
            end
        end
    end
endmodule

// File: tb/tb_dfp_sig_divide.sv
// tb_dfp_sig_divide: scoreboard bench for dfp_sig_divide with N=4.
// Expected results come from integer division of the decoded operands.
module tb_dfp_sig_divide;
    localparam int N = 4;

    logic        clk = 0;
    logic        rst_n = 1;
    logic        ce = 1;
    logic        ld = 0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [31:0] q;
    logic [19:0] r;
    logic [7:0]  lzcnt;
    logic        dbz;
    logic        done;

    dfp_sig_divide #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .ld(ld), .a(a), .b(b),
        .q(q), .r(r), .lzcnt(lzcnt), .dbz(dbz), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [19:0] r;
        logic [7:0]  lz;
        logic        dbz;
        int          lat;
        int          stall;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_w = 0;
    int          cyc_ce = 0;
    logic        ld_hit = 0;
    logic [15:0] ld_b = '0;
    logic        busy = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic longint bcd2int(input logic [63:0] v, input int nd);
        longint s;
        s = 0;
        for (int i = nd-1; i >= 0; i--) s = s*10 + longint'(v[i*4 +: 4]);
        return s;
    endfunction

    function automatic logic [63:0] int2bcd(input longint x, input int nd);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nd; i++) begin
            v[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return v;
    endfunction

    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input int stall);
        exp_t   e;
        longint ai, bi, qi, ri, p;
        int     lz, sum, dig;
        bit     seen;
        ai = bcd2int({48'h0, av}, 4);
        bi = bcd2int({48'h0, bv}, 4);
        e.stall = stall;
        if (bi == 0) begin
            e.q = '0; e.r = '0; e.lz = 8'h08; e.dbz = 1'b1; e.lat = 0;
            return e;
        end
        qi = ai * 10000 / bi;
        ri = ai * 10000 % bi;
        lz = 0; sum = 0; seen = 0; p = 10000000;
        for (int i = 0; i < 8; i++) begin
            dig = int'((qi / p) % 10);
            sum += dig;
            if (dig != 0) seen = 1;
            if (!seen) lz++;
            p = p / 10;
        end
        e.q = 32'(int2bcd(qi, 8));
        e.r = 20'(int2bcd(ri, 5));
        e.lz = 8'(lz);
        e.dbz = 1'b0;
        e.lat = 2*N + sum;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc_w++;
        if (ce) cyc_ce++;
        if (ce && ld && rst_n) begin
            ld_hit = 1;
            ld_b = b;
            cyc_w = 0;
            cyc_ce = 0;
        end
    end

    always @(negedge rst_n) busy = 0;

    always @(negedge clk) begin
        exp_t e;
        logic cmp;
        cmp = 0;
        if (ld_hit) begin
            chk("done_on_ld", {63'h0, done}, {63'h0, ld_b == 16'h0});
            if (ld_b == 16'h0) cmp = 1;
            else busy = 1;
            ld_hit = 0;
        end else if (busy && done && rst_n) begin
            cmp = 1;
            busy = 0;
        end
        if (cmp) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_completion: got a completion expected none");
            end else begin
                e = sb.pop_front();
                chk("q", {32'h0, q}, {32'h0, e.q});
                chk("r", {44'h0, r}, {44'h0, e.r});
                chk("lzcnt", {56'h0, lzcnt}, {56'h0, e.lz});
                chk("dbz", {63'h0, dbz}, {63'h0, e.dbz});
                if (!e.dbz) begin
                    chk("latency", 64'(cyc_w), 64'(e.lat + e.stall));
                    chk("ce_cycles", 64'(cyc_ce), 64'(e.lat));
                end
            end
        end
    end

    task automatic do_ld(input logic [15:0] av, input logic [15:0] bv, input bit push, input int stall = 0);
        @(negedge clk);
        a = av;
        b = bv;
        ld = 1;
        if (push) sb.push_back(model(av, bv, stall));
        @(negedge clk);
        ld = 0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
            busy = 0;
        end
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_done"}, {63'h0, done}, 64'h1);
        chk({tag, "_q"}, {32'h0, q}, 64'h0);
        chk({tag, "_r"}, {44'h0, r}, 64'h0);
        chk({tag, "_lzcnt"}, {56'h0, lzcnt}, 64'h0);
        chk({tag, "_dbz"}, {63'h0, dbz}, 64'h0);
    endtask

    function automatic logic [15:0] rnd_bcd(input int v);
        return 16'(int2bcd(longint'(v), 4));
    endfunction

    initial begin
        #1 rst_n = 0;
        #1 chk_reset("reset");
        @(negedge clk);
        rst_n = 1;
        do_ld(16'h1234, 16'h0002, 1); wait_idle();
        do_ld(16'h0001, 16'h0003, 1); wait_idle();
        do_ld(16'h9999, 16'h0001, 1); wait_idle();
        do_ld(16'h5555, 16'h0000, 1); wait_idle();
        do_ld(16'h0000, 16'h0007, 1); wait_idle();
        do_ld(16'h9999, 16'h0001, 0);
        repeat (8) @(negedge clk);
        do_ld(16'h1234, 16'h0002, 1); wait_idle();
        do_ld(16'h0000, 16'h0007, 0);
        repeat (6) @(negedge clk);
        do_ld(16'h0001, 16'h0003, 1); wait_idle();
        do_ld(16'h1234, 16'h0002, 1, 5);
        repeat (3) @(negedge clk);
        ce = 0;
        repeat (5) @(negedge clk);
        ce = 1;
        wait_idle();
        do_ld(16'h0001, 16'h0003, 1); wait_idle();
        do_ld(16'h0000, 16'h0007, 0);
        repeat (6) @(negedge clk);
        #2 rst_n = 0;
        #1 chk_reset("midrun_reset");
        @(negedge clk);
        rst_n = 1;
        do_ld(16'h1234, 16'h0002, 1); wait_idle();
        for (int i = 0; i < 24; i++) begin
            logic [15:0] av, bv;
            av = rnd_bcd(int'($urandom_range(0, 9999)));
            bv = ($urandom_range(0, 3) == 0) ? rnd_bcd(int'($urandom_range(0, 20)))
                                             : rnd_bcd(int'($urandom_range(0, 9999)));
            do_ld(av, bv, 1);
            wait_idle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
